// File: rtl/calculator_core.sv
// calculator_core: four-button / four-slider accumulator calculator.
// Buttons are debounced levels. Each one is edge-detected against a registered
// history, so one press gives one event however long the button is held.
// Optional feature: define CALC_SATURATE_EN to clamp the result on signed
// overflow instead of wrapping modulo 2^WIDTH.
module calculator_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_clr,
  input  logic             button_ent,
  input  logic             button_add,
  input  logic             button_sub,
  input  logic             slider_1,
  input  logic             slider_2,
  input  logic             slider_3,
  input  logic             slider_4,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       operand,
  output logic             op_sub,
  output logic             overflow,
  output logic             result_valid,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READY  = 2'd1;
  localparam logic [1:0] OP_SEL = 2'd2;
  localparam logic [1:0] EXEC   = 2'd3;

  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_nx;
  logic [3:0]       btn_lvl, btn_hist, evt;
  logic             first_smp;
  logic             clr_e, ent_e, add_e, sub_e;
  logic [3:0]       b_q;
  logic [WIDTH:0]   a_x, b_x, sum;
  logic             ovf_det;
  logic [WIDTH-1:0] res_nx;

  assign operand = {slider_4, slider_3, slider_2, slider_1};
  assign btn_lvl = {button_clr, button_ent, button_add, button_sub};

  // Button history. The first sample after reset only loads the history, so a
  // button held through reset release is not seen as a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_hist  <= '0;
      first_smp <= 1'b1;
    end else begin
      btn_hist  <= btn_lvl;
      first_smp <= 1'b0;
    end
  end

  assign evt = btn_lvl & ~btn_hist & {4{~first_smp}};
  assign clr_e = evt[3];
  assign ent_e = evt[2];
  assign add_e = evt[1];
  assign sub_e = evt[0];

  // Signed add/sub one bit wider; the overflow is where the top two bits disagree.
  // B is a zero-extended nibble, so it is always non-negative.
  assign a_x = {result[WIDTH-1], result};
  assign b_x = {{(WIDTH-3){1'b0}}, b_q};
  assign sum = op_sub ? (a_x - b_x) : (a_x + b_x);
  assign ovf_det = sum[WIDTH] ^ sum[WIDTH-1];

`ifdef CALC_SATURATE_EN
  assign res_nx = ovf_det ? (sum[WIDTH] ? S_MIN : S_MAX) : sum[WIDTH-1:0];
`else
  assign res_nx = sum[WIDTH-1:0];
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  // FSM next state: clr overrides everything, and EXEC always lasts one cycle
  always_comb begin
    state_nx = state_q;
    if (clr_e) state_nx = IDLE;
    else begin
      case (state_q)
        IDLE:    if (ent_e) state_nx = READY;
        READY:   if (add_e || sub_e) state_nx = OP_SEL;
        OP_SEL:  if (ent_e) state_nx = EXEC;
        default: state_nx = READY;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    state = state_q;
  end

  // Datapath: accumulator, operand B, operation select, sticky overflow, valid pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      b_q          <= '0;
      op_sub       <= 1'b0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clr_e) begin
        result   <= '0;
        overflow <= 1'b0;
        op_sub   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (ent_e) begin
            result   <= {{(WIDTH-4){1'b0}}, operand};
            overflow <= 1'b0;
          end
          READY, OP_SEL: begin
            // add wins over a simultaneous sub
            if (add_e)      op_sub <= 1'b0;
            else if (sub_e) op_sub <= 1'b1;
            if (state_q == OP_SEL && ent_e) b_q <= operand;
          end
          default: begin
            result       <= res_nx;
            overflow     <= overflow | ovf_det;
            result_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calculator_core.sv
module tb_calculator_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button_clr = 0, button_ent = 0, button_add = 0, button_sub = 0;
  logic       slider_1 = 0, slider_2 = 0, slider_3 = 0, slider_4 = 0;
  logic [7:0] result;
  logic [3:0] operand;
  logic       op_sub, overflow, result_valid;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int rv_cnt  = 0;

  localparam logic [3:0] CLR = 4'b1000, ENT = 4'b0100, ADD = 4'b0010, SUB = 4'b0001;

  calculator_core #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .button_clr(button_clr), .button_ent(button_ent),
    .button_add(button_add), .button_sub(button_sub),
    .slider_1(slider_1), .slider_2(slider_2), .slider_3(slider_3), .slider_4(slider_4),
    .result(result), .operand(operand), .op_sub(op_sub), .overflow(overflow),
    .result_valid(result_valid), .state(state)
  );

  always #5 clk = ~clk;

  // count cycles in which result_valid is high
  always @(negedge clk) if (result_valid === 1'b1) rv_cnt = rv_cnt + 1;

  task automatic set_sl(input logic [3:0] v);
    {slider_4, slider_3, slider_2, slider_1} = v;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {button_clr, button_ent, button_add, button_sub} = b;
  endtask

  // one-cycle press; returns at the negedge just after the event edge
  task automatic press(input logic [3:0] b);
    @(negedge clk); set_btn(b);
    @(negedge clk); set_btn(4'b0); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; #3;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
    n_tests++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h exp 00", result); end
    n_tests++; if ({op_sub, overflow, result_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {op_sub, overflow, result_valid}); end
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_load;
    set_sl(4'b0101); rv_cnt = 0; #1;
    n_tests++; if (operand !== 4'h5) begin n_fail++; $display("FAIL operand got %h exp 5", operand); end
    press(ENT); wait_cyc(2);
    n_tests++; if (result !== 8'h05) begin n_fail++; $display("FAIL load_result got %h exp 05", result); end
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL load_state got %0d exp 1", state); end
    n_tests++; if (rv_cnt !== 0) begin n_fail++; $display("FAIL load_valid got %0d pulses exp 0", rv_cnt); end
  endtask

  task automatic test_add;
    press(ADD);
    n_tests++; if ({state, op_sub} !== {2'd2, 1'b0}) begin n_fail++; $display("FAIL add_sel got st=%0d op=%b exp st=2 op=0", state, op_sub); end
    set_sl(4'b0011); rv_cnt = 0;
    press(ENT);
    n_tests++; if (state !== 2'd3) begin n_fail++; $display("FAIL add_exec got %0d exp 3", state); end
    wait_cyc(3);
    n_tests++; if (result !== 8'h08) begin n_fail++; $display("FAIL add_result got %h exp 08", result); end
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL add_ready got %0d exp 1", state); end
    n_tests++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL add_valid got %0d pulses exp 1", rv_cnt); end
  endtask

  task automatic test_sub;
    press(SUB);
    n_tests++; if ({state, op_sub} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL sub_sel got st=%0d op=%b exp st=2 op=1", state, op_sub); end
    set_sl(4'b1111);
    press(ENT); wait_cyc(3);
    n_tests++; if (result !== 8'hF9) begin n_fail++; $display("FAIL sub_result got %h exp f9", result); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sub_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp8, exp9;
`ifdef CALC_SATURATE_EN
    exp8 = 8'h7F; exp9 = 8'h7E;
`else
    exp8 = 8'h87; exp9 = 8'h86;
`endif
    rv_cnt = 0;
    press(CLR);
    n_tests++; if ({state, result} !== {2'd0, 8'h00}) begin n_fail++; $display("FAIL clr got st=%0d res=%h exp st=0 res=00", state, result); end
    set_sl(4'b1111);
    press(ENT);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        n_tests++; if ({result, overflow} !== {8'h78, 1'b0}) begin n_fail++; $display("FAIL ovf_pre got res=%h ovf=%b exp res=78 ovf=0", result, overflow); end
      end
      press(ADD); press(ENT); wait_cyc(2);
    end
    n_tests++; if (result !== exp8) begin n_fail++; $display("FAIL ovf_result got %h exp %h", result, exp8); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_tests++; if (rv_cnt !== 8) begin n_fail++; $display("FAIL ovf_valid got %0d pulses exp 8", rv_cnt); end
    press(SUB); set_sl(4'b0001); press(ENT); wait_cyc(2);
    n_tests++; if ({result, overflow} !== {exp9, 1'b1}) begin n_fail++; $display("FAIL ovf_sticky got res=%h ovf=%b exp res=%h ovf=1", result, overflow, exp9); end
    press(CLR);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overflow); end
  endtask

  task automatic test_hold;
    set_sl(4'b0001); press(ENT);
    // hold add 50 cycles; a single sub press mid-hold must stick
    @(negedge clk); button_add = 1'b1;
    repeat (20) @(negedge clk);
    button_sub = 1'b1; @(negedge clk); button_sub = 1'b0;
    repeat (29) @(negedge clk); #1;
    n_tests++; if ({state, op_sub} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL hold got st=%0d op=%b exp st=2 op=1", state, op_sub); end
    @(negedge clk); button_add = 1'b0; #1;
    press(ADD | SUB);
    n_tests++; if ({state, op_sub} !== {2'd2, 1'b0}) begin n_fail++; $display("FAIL addsub got st=%0d op=%b exp st=2 op=0", state, op_sub); end
    rv_cnt = 0;
    press(CLR | ENT); wait_cyc(2);
    n_tests++; if ({state, result} !== {2'd0, 8'h00}) begin n_fail++; $display("FAIL clr_ent got st=%0d res=%h exp st=0 res=00", state, result); end
    n_tests++; if (rv_cnt !== 0) begin n_fail++; $display("FAIL clr_valid got %0d pulses exp 0", rv_cnt); end
  endtask

  task automatic test_reset_exec;
    set_sl(4'b0100); press(ENT);
    press(ADD);
    rv_cnt = 0;
    @(negedge clk); button_ent = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (state !== 2'd3) begin n_fail++; $display("FAIL rexec_pre got %0d exp 3", state); end
    reset = 1'b0; #1;
    n_tests++; if ({state, result, op_sub, overflow, result_valid} !== {2'd0, 8'h00, 3'b000}) begin
      n_fail++; $display("FAIL rexec_abort got st=%0d res=%h flags=%b exp st=0 res=00 flags=000", state, result, {op_sub, overflow, result_valid}); end
    wait_cyc(2);
    reset = 1'b1;      // ent still held high through release
    wait_cyc(5);
    n_tests++; if ({state, rv_cnt} !== {2'd0, 32'd0}) begin n_fail++; $display("FAIL rexec_held got st=%0d pulses=%0d exp st=0 pulses=0", state, rv_cnt); end
    button_ent = 1'b0;
    press(ENT);
    n_tests++; if ({state, result} !== {2'd1, 8'h04}) begin n_fail++; $display("FAIL rexec_repress got st=%0d res=%h exp st=1 res=04", state, result); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_add;
    test_sub;
    test_overflow;
    test_hold;
    test_reset_exec;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calculator_core.md
CALCULATOR_CORE -- requirements
Module: calculator_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, accumulator/result width in bits (two's complement, WIDTH >= 5).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports button_clr, button_ent, button_add, button_sub  input  1 each  debounced button levels.
REQ-005 SHALL have ports slider_1, slider_2, slider_3, slider_4  input  1 each  debounced slider levels; slider_1 = operand bit 0, slider_4 = bit 3.
REQ-006 SHALL have port result  output  WIDTH  accumulator value, signed.
REQ-007 SHALL have port operand  output  4  current slider value {slider_4..slider_1}, combinational.
REQ-008 SHALL have port op_sub  output  1  selected operation (0 add, 1 sub).
REQ-009 SHALL have port overflow  output  1  sticky signed-overflow flag.
REQ-010 SHALL have port result_valid  output  1  one-cycle pulse when result updates from an operation.
REQ-011 SHALL have port state  output  2  FSM state encoding: IDLE=0, READY=1, OP_SEL=2, EXEC=3.

Function
REQ-012 SHALL register each button level every cycle; a press event is level=1 with previous registered level=0, acted on at that same clock edge.
REQ-013 SHALL produce exactly one event per press regardless of hold duration.
REQ-014 SHALL treat operand as zero-extended to WIDTH.
REQ-015 IDLE: ent event -> result <= operand, overflow <= 0, go READY; add/sub events ignored.
REQ-016 READY: add event -> op_sub <= 0, go OP_SEL; sub event -> op_sub <= 1, go OP_SEL; ent ignored.
REQ-017 OP_SEL: ent event -> latch operand into internal B, go EXEC; add/sub events re-select op_sub, stay OP_SEL.
REQ-018 EXEC: exactly one cycle; result <= result +/- B per op_sub; result_valid = 1 for that cycle only; go READY.
REQ-019 Overflow detected when operands' signs make a signed WIDTH-bit result out of range; overflow set and held until clr event, reset, or IDLE ent load.
REQ-020 clr event in any state -> result <= 0, overflow <= 0, op_sub <= 0, go IDLE; clr has priority over all simultaneous events.
REQ-021 Simultaneous add and sub events: add wins.
REQ-022 Simultaneous ent with add/sub in READY: add/sub taken, ent ignored; in OP_SEL: ent taken, op from add/sub applied first (same edge).
REQ-023 Button events arriving while in EXEC are ignored except clr.
REQ-024 result_valid SHALL never assert on IDLE load or clr.

Reset
REQ-025 reset low SHALL immediately force state=IDLE, result=0, B=0, op_sub=0, overflow=0, result_valid=0, button history registers=0.
REQ-026 Reset asserted mid-EXEC SHALL abort the operation with no result_valid pulse.
REQ-027 A button held high through reset release SHALL NOT generate an event until released and pressed again (history register loads 1 on first sampled cycle without event... history resets to 1 only after first sample; first-cycle high level counts as no event).

Configuration
REQ-028 Macro CALC_SATURATE_EN defined: on overflow result clamps to +(2^(WIDTH-1)-1) or -2^(WIDTH-1) per direction; overflow still set.
REQ-029 Macro CALC_SATURATE_EN undefined: result wraps modulo 2^WIDTH; overflow set.

Verification (WIDTH=8)
REQ-030 Reset, sliders=0101, press ent -> result=0x05, state=READY, result_valid stays 0.
REQ-031 Then press add, sliders=0011, press ent -> EXEC one cycle, result=0x08, result_valid high exactly 1 cycle; press sub, sliders=1111, ent -> result=0xF9 (-7).
REQ-032 Load 15, add 15 eight times -> after 8th: no macro result=0x87, overflow=1; with CALC_SATURATE_EN result=0x7F, overflow=1; further ops keep overflow=1.
REQ-033 Hold add high 50 cycles in READY -> single transition to OP_SEL; press add+sub same cycle -> op_sub=0; press clr with ent same cycle in OP_SEL -> state=IDLE, result=0.
REQ-034 Assert reset during EXEC -> outputs at reset values immediately, no result_valid; button held through release produces no event.
